// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the PWM dead-time stage: FSM state encoding and default field width.
package pwm_deadtime_pkg;

  localparam int DTW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    H_ON      = 3'd1,
    DEAD_TO_L = 3'd2,
    L_ON      = 3'd3,
    DEAD_TO_H = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_deadtime_dt_counter.sv
// Loadable dead-band down-counter; holds at zero and flags it for the FSM.
module pwm_deadtime_dt_counter
  import pwm_deadtime_pkg::*;
#(
  parameter int DTW = DTW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           dec,
  input  logic [DTW-1:0] load_val,
  output logic           zero
);

  logic [DTW-1:0] cnt_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (load) begin
      cnt_p0 <= load_val;
    end else if (dec && !zero) begin
      cnt_p0 <= cnt_p0 - DTW'(1);
    end
  end

  assign zero = (cnt_p0 == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary PWM output stage with programmable rise/fall dead bands and per-side polarity.
// Optional trip input enabled by defining PWM_DEADTIME_FAULT_EN.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int DTW = DTW_DEF
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic           EN,
  input  logic           PWM_IN,
  input  logic [DTW-1:0] DT_RISE,
  input  logic [DTW-1:0] DT_FALL,
  input  logic           POL_H,
  input  logic           POL_L,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic           FAULT,
  input  logic           FAULT_CLR,
  output logic           FAULT_STS,
`endif
  output logic           PWM_H,
  output logic           PWM_L,
  output logic           DEAD
);

  state_t         state_p0, state_nxt;
  state_t         rise_tgt, fall_tgt;
  logic           h_act_p0, l_act_p0, dead_p0;
  logic           force_idle;
  logic           cnt_ld, cnt_dec, cnt_zero;
  logic [DTW-1:0] cnt_ld_val;

`ifdef PWM_DEADTIME_FAULT_EN
  logic fault_meta_p0, fault_sync_p1, fault_sts_p0;

  // Trip synchronizer and sticky status; a set always wins over a clear
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      fault_meta_p0 <= 1'b0;
      fault_sync_p1 <= 1'b0;
      fault_sts_p0  <= 1'b0;
    end else begin
      fault_meta_p0 <= FAULT;
      fault_sync_p1 <= fault_meta_p0;
      if (fault_sync_p1) begin
        fault_sts_p0 <= 1'b1;
      end else if (FAULT_CLR) begin
        fault_sts_p0 <= 1'b0;
      end
    end
  end

  assign force_idle = !EN || fault_sync_p1 || fault_sts_p0;
  assign FAULT_STS  = fault_sts_p0;
`else
  assign force_idle = !EN;
`endif

  // A zero dead time skips the band entirely
  assign rise_tgt   = (DT_RISE == '0) ? H_ON : DEAD_TO_H;
  assign fall_tgt   = (DT_FALL == '0) ? L_ON : DEAD_TO_L;
  assign cnt_ld_val = (PWM_IN ? DT_RISE : DT_FALL) - DTW'(1);

  always_comb begin
    state_nxt = state_p0;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    if (force_idle) begin
      state_nxt = IDLE;
    end else begin
      unique case (state_p0)
        IDLE: begin
          state_nxt = PWM_IN ? rise_tgt : fall_tgt;
          cnt_ld    = (state_nxt == DEAD_TO_H) || (state_nxt == DEAD_TO_L);
        end
        L_ON: begin
          if (PWM_IN) begin
            state_nxt = rise_tgt;
            cnt_ld    = (rise_tgt == DEAD_TO_H);
          end
        end
        H_ON: begin
          if (!PWM_IN) begin
            state_nxt = fall_tgt;
            cnt_ld    = (fall_tgt == DEAD_TO_L);
          end
        end
        // Reversal inside a band is safe: the side being waited for never turned on
        DEAD_TO_H: begin
          if (!PWM_IN) begin
            state_nxt = L_ON;
          end else if (cnt_zero) begin
            state_nxt = H_ON;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        DEAD_TO_L: begin
          if (PWM_IN) begin
            state_nxt = H_ON;
          end else if (cnt_zero) begin
            state_nxt = L_ON;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  pwm_deadtime_dt_counter #(.DTW(DTW)) dt_counter (
    .clk      (PCLK),
    .rst      (PRESET),
    .load     (cnt_ld),
    .dec      (cnt_dec),
    .load_val (cnt_ld_val),
    .zero     (cnt_zero)
  );

  // State and drive-active flags register together from the next state
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_p0 <= IDLE;
      h_act_p0 <= 1'b0;
      l_act_p0 <= 1'b0;
      dead_p0  <= 1'b1;
    end else begin
      state_p0 <= state_nxt;
      h_act_p0 <= (state_nxt == H_ON);
      l_act_p0 <= (state_nxt == L_ON);
      dead_p0  <= !((state_nxt == H_ON) || (state_nxt == L_ON));
    end
  end

  // Polarity is static configuration, applied after the active flags
  assign PWM_H = h_act_p0 ^ POL_H;
  assign PWM_L = l_act_p0 ^ POL_L;
  assign DEAD  = dead_p0;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime against a run-length reference model.
module tb_pwm_deadtime;

  localparam int DTW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           pwm_in = 1'b0;
  logic           pol_h = 1'b0;
  logic           pol_l = 1'b1;
  logic [DTW-1:0] dt_rise = '0;
  logic [DTW-1:0] dt_fall = '0;
  logic           pwm_h, pwm_l, dead;
`ifdef PWM_DEADTIME_FAULT_EN
  logic           fault = 1'b0;
  logic           fault_clr = 1'b0;
  logic           fault_sts;
  logic           m_q1 = 1'b0, m_q2 = 1'b0, m_sts = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: the current PWM_IN run owns the outputs once it has
  // outlasted the dead band latched at its start, or at once if it cut short
  // an unfinished band of the previous run.
  bit run_valid = 0;
  bit run_lvl = 0;
  bit run_direct = 0;
  bit m_act = 0;
  int run_len = 0;
  int run_n = 0;

  always #5 clk = ~clk;

  pwm_deadtime #(.DTW(DTW)) dut (
    .PCLK    (clk),
    .PRESET  (rst),
    .EN      (en),
    .PWM_IN  (pwm_in),
    .DT_RISE (dt_rise),
    .DT_FALL (dt_fall),
    .POL_H   (pol_h),
    .POL_L   (pol_l),
`ifdef PWM_DEADTIME_FAULT_EN
    .FAULT     (fault),
    .FAULT_CLR (fault_clr),
    .FAULT_STS (fault_sts),
`endif
    .PWM_H   (pwm_h),
    .PWM_L   (pwm_l),
    .DEAD    (dead)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pwm_h", pwm_h, (m_act && run_lvl) ^ pol_h);
    chk("pwm_l", pwm_l, (m_act && !run_lvl) ^ pol_l);
    chk("dead", dead, !m_act);
    chk("overlap", (pwm_h ^ pol_h) && (pwm_l ^ pol_l), 1'b0);
`ifdef PWM_DEADTIME_FAULT_EN
    chk("fault_sts", fault_sts, m_sts);
`endif
  endtask

  task automatic model_edge();
    bit idle;
    idle = rst || !en;
`ifdef PWM_DEADTIME_FAULT_EN
    if (rst) begin
      m_q1 = 0; m_q2 = 0; m_sts = 0;
    end else begin
      idle = idle || m_q2 || m_sts;
      if (m_q2) m_sts = 1;
      else if (fault_clr) m_sts = 0;
      m_q2 = m_q1;
      m_q1 = fault;
    end
`endif
    if (idle) begin
      run_valid = 0;
      m_act = 0;
    end else if (!run_valid || pwm_in != run_lvl) begin
      run_direct = run_valid && !m_act;
      run_valid = 1;
      run_lvl = pwm_in;
      run_len = 1;
      run_n = pwm_in ? int'(dt_rise) : int'(dt_fall);
      m_act = run_direct || (run_len > run_n);
    end else begin
      if (run_len < 100000) run_len++;
      m_act = run_direct || (run_len > run_n);
    end
  endtask

  // One clock: model the edge, then check on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit h_seen;
    int gap;

    // Reset state with mixed polarity
    rst = 1; en = 0; pwm_in = 0; pol_h = 0; pol_l = 1; dt_fall = 3; dt_rise = 0;
    step();
    step();
    chk("rst_h", pwm_h, 1'b0);
    chk("rst_l", pwm_l, 1'b1);
    chk("rst_dead", dead, 1'b1);

    // Leaving IDLE low: L active exactly 3 cycles after the band starts
    rst = 0; en = 1;
    step();
    step();
    step();
    chk("tp1_l_still_off", pwm_l, 1'b1);
    step();
    chk("tp1_l_on", pwm_l, 1'b0);
    chk("tp1_dead_clear", dead, 1'b0);

    // 50% PWM, period 20, asymmetric dead bands
    pol_l = 0; dt_rise = 4; dt_fall = 2;
    for (int i = 0; i < 80; i++) begin
      pwm_in = ((i % 20) < 10);
      step();
    end

    // A pulse no longer than the rise band never reaches H
    dt_rise = 5; pwm_in = 0;
    for (int i = 0; i < 8; i++) step();
    h_seen = 0;
    pwm_in = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (pwm_h) h_seen = 1;
    end
    pwm_in = 0;
    step();
    chk("tp3_h_never", h_seen, 1'b0);
    chk("tp3_l_back", pwm_l, 1'b1);

    // Zero dead time: direct swap on one edge
    dt_rise = 0; dt_fall = 0;
    for (int i = 0; i < 24; i++) begin
      pwm_in = (i % 3 == 0) ? ~pwm_in : pwm_in;
      step();
    end

    // EN drop in H_ON, re-enable low with a 6-cycle fall band
    dt_rise = 2; pwm_in = 1;
    for (int i = 0; i < 5; i++) step();
    chk("tp5_h_on", pwm_h, 1'b1);
    en = 0;
    step();
    en = 1; pwm_in = 0; dt_fall = 6;
    gap = 1;
    for (int i = 0; i < 20 && pwm_l !== 1'b1; i++) begin
      step();
      if (pwm_l !== 1'b1) gap++;
    end
    chk("tp5_gap_is_7", gap == 7, 1'b1);

    // Asynchronous reset while H is driven
    pwm_in = 1; dt_rise = 1;
    for (int i = 0; i < 4; i++) step();
    chk("arst_h_before", pwm_h, 1'b1);
    #2 rst = 1;
    #1;
    chk("arst_h_off", pwm_h, pol_h);
    chk("arst_dead", dead, 1'b1);
    step();
    rst = 0;

    // Randomized traffic in four polarity segments
    for (int seg = 0; seg < 4; seg++) begin
      pol_h = seg[0];
      pol_l = seg[1];
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(5, 0) == 0) pwm_in = ~pwm_in;
        if ($urandom_range(7, 0) == 0) dt_rise = DTW'($urandom_range(6, 0));
        if ($urandom_range(7, 0) == 0) dt_fall = DTW'($urandom_range(6, 0));
        en = ($urandom_range(39, 0) != 0);
        step();
      end
    end

`ifdef PWM_DEADTIME_FAULT_EN
    // Trip in H_ON, ignored clear while tripped, then recovery through a band
    en = 1; pol_h = 0; pol_l = 0; dt_rise = 2; dt_fall = 2; pwm_in = 1;
    for (int i = 0; i < 6; i++) step();
    chk("flt_h_on", pwm_h, 1'b1);
    fault = 1;
    for (int i = 0; i < 3; i++) step();
    chk("flt_h_off", pwm_h, 1'b0);
    chk("flt_sts_set", fault_sts, 1'b1);
    fault_clr = 1;
    step();
    fault_clr = 0;
    chk("flt_clr_ignored", fault_sts, 1'b1);
    fault = 0;
    for (int i = 0; i < 4; i++) step();
    chk("flt_still_held", dead, 1'b1);
    fault_clr = 1;
    step();
    fault_clr = 0;
    chk("flt_sts_cleared", fault_sts, 1'b0);
    step();
    chk("flt_band_entry", dead, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("flt_resumed", pwm_h, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
